// File: rtl/cfu_li1_share_arb_if.sv
// Bundle of every requester-side and CFU-side signal of the shared CFU arbiter.
// The arbiter connects through the slave modport; the environment (requesters
// together with the CFU instance) connects through the master modport.
interface cfu_li1_share_arb_if #(
  parameter int N_REQ           = 2,
  parameter int CFU_FUNC_ID_W   = 5,
  parameter int CFU_REQ_DATA_W  = 32,
  parameter int CFU_RESP_DATA_W = 32,
  parameter int CFU_ERR_ID_W    = 32
);
  // Requester side
  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ-1:0]                req_ready;
  logic [N_REQ-1:0]                req_last;
  logic [N_REQ*CFU_FUNC_ID_W-1:0]  req_func_id;
  logic [N_REQ*CFU_REQ_DATA_W-1:0] req_data0;
  logic [N_REQ*CFU_REQ_DATA_W-1:0] req_data1;
  logic [N_REQ-1:0]                resp_valid;
  logic [CFU_RESP_DATA_W-1:0]      resp_data;
  logic [N_REQ-1:0]                resp_err;
  logic [CFU_ERR_ID_W-1:0]         resp_err_id;

  // CFU side
  logic                            cfu_req_valid;
  logic [CFU_FUNC_ID_W-1:0]        cfu_req_func_id;
  logic [CFU_REQ_DATA_W-1:0]       cfu_req_data0;
  logic [CFU_REQ_DATA_W-1:0]       cfu_req_data1;
  logic                            cfu_resp_valid;
  logic [CFU_RESP_DATA_W-1:0]      cfu_resp_data;
  logic                            cfu_resp_err;
  logic [CFU_ERR_ID_W-1:0]         cfu_resp_err_id;

  modport master (
    output req_valid, req_last, req_func_id, req_data0, req_data1,
    input  req_ready, resp_valid, resp_data, resp_err, resp_err_id,
    input  cfu_req_valid, cfu_req_func_id, cfu_req_data0, cfu_req_data1,
    output cfu_resp_valid, cfu_resp_data, cfu_resp_err, cfu_resp_err_id
  );

  modport slave (
    input  req_valid, req_last, req_func_id, req_data0, req_data1,
    output req_ready, resp_valid, resp_data, resp_err, resp_err_id,
    output cfu_req_valid, cfu_req_func_id, cfu_req_data0, cfu_req_data1,
    input  cfu_resp_valid, cfu_resp_data, cfu_resp_err, cfu_resp_err_id
  );
endinterface

// File: rtl/cfu_li1_share_arb.sv
// Round-robin arbiter sharing one fixed-latency stateful CFU among N_REQ
// requesters. A requester keeps the CFU locked for a whole session (until it
// sends req_last, or until it idles for LOCK_TIMEOUT cycles) so its
// accumulator state is never interleaved with another requester's. Each issued
// op is tagged with its issuer and the tag travels alongside the CFU pipeline
// so the response can be steered back.
module cfu_li1_share_arb #(
  parameter int N_REQ            = 2,
  parameter int CFU_FUNC_ID_W    = 5,
  parameter int CFU_REQ_DATA_W   = 32,
  parameter int CFU_RESP_DATA_W  = 32,
  parameter int CFU_ERR_ID_W     = 32,
  parameter int CFU_RESP_LATENCY = 3,
  parameter int LOCK_TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                rst,
  cfu_li1_share_arb_if.slave  bus,
  output logic                timeout,
  output logic                protocol_err
);

  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IDW1  = IDW + 1;
  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int LAT   = CFU_RESP_LATENCY;
  localparam int FW    = CFU_FUNC_ID_W;
  localparam int DW    = CFU_REQ_DATA_W;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_reg, state_next;
  logic [IDW-1:0]     owner_reg, owner_next;
  logic [IDW-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic               timeout_reg, timeout_next;
  logic               protocol_err_reg;

  logic [IDW:0]       cand;
  logic               search_found;
  logic [IDW-1:0]     search_idx;
  logic [IDW-1:0]     grant_idx;
  logic               accept;
  logic [N_REQ-1:0]   ready_vec;

  logic               tag_valid_reg [LAT];
  logic [IDW-1:0]     tag_id_reg    [LAT];
  logic               tag_valid;
  logic [IDW-1:0]     tag_id;

  logic [FW-1:0]      func_arr  [N_REQ];
  logic [DW-1:0]      data0_arr [N_REQ];
  logic [DW-1:0]      data1_arr [N_REQ];

  // Next requester index after x, wrapping at N_REQ (N_REQ need not be 2^k).
  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
    logic [IDW:0] s;
    s = {1'b0, x} + IDW1'(1);
    if (s >= IDW1'(N_REQ)) s = '0;
    return s[IDW-1:0];
  endfunction

  // Unpack the flattened requester buses into per-requester slices.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign func_arr[gi]  = bus.req_func_id[gi*FW +: FW];
      assign data0_arr[gi] = bus.req_data0[gi*DW +: DW];
      assign data1_arr[gi] = bus.req_data1[gi*DW +: DW];
    end
  endgenerate

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    cand         = '0;
    search_found = 1'b0;
    search_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + IDW1'(k);
      if (cand >= IDW1'(N_REQ)) cand = cand - IDW1'(N_REQ);
      if (!search_found && bus.req_valid[cand[IDW-1:0]]) begin
        search_found = 1'b1;
        search_idx   = cand[IDW-1:0];
      end
    end
  end

  // Session FSM: grant/lock decisions, idle counting and forced release.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    idle_cnt_next = idle_cnt_reg;
    timeout_next  = 1'b0;
    grant_idx     = search_idx;
    accept        = 1'b0;
    ready_vec     = '0;
    case (state_reg)
      IDLE: begin
        if (search_found) begin
          accept                = 1'b1;
          ready_vec[search_idx] = 1'b1;
          if (bus.req_last[search_idx]) begin
            rr_ptr_next = inc_mod(search_idx);
          end else begin
            owner_next    = search_idx;
            state_next    = LOCKED;
            idle_cnt_next = '0;
          end
        end
      end
      LOCKED: begin
        grant_idx = owner_reg;
        if (bus.req_valid[owner_reg]) begin
          // An owner op always wins over a timeout in the same cycle.
          accept               = 1'b1;
          ready_vec[owner_reg] = 1'b1;
          if (bus.req_last[owner_reg]) begin
            state_next  = IDLE;
            rr_ptr_next = inc_mod(owner_reg);
          end else begin
            idle_cnt_next = '0;
          end
        end else if (LOCK_TIMEOUT != 0) begin
          if (idle_cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
            // Accumulator is left as is; the next owner restarts with func 0.
            state_next   = IDLE;
            rr_ptr_next  = inc_mod(owner_reg);
            timeout_next = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Nothing is accepted while reset is held.
    if (rst) begin
      accept    = 1'b0;
      ready_vec = '0;
    end
  end

  // FSM and arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      idle_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      idle_cnt_reg <= idle_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Tag pipeline stage 0 captures the issuer of the op sent this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_reg[0] <= 1'b0;
      tag_id_reg[0]    <= '0;
    end else begin
      tag_valid_reg[0] <= accept;
      tag_id_reg[0]    <= accept ? grant_idx : '0;
    end
  end

  generate
    for (gi = 1; gi < LAT; gi++) begin : g_tag_pipe
      // Later tag stages shift in lock-step with the CFU pipeline.
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_id_reg[gi]    <= '0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_id_reg[gi]    <= tag_id_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tag_valid = tag_valid_reg[LAT-1];
  assign tag_id    = tag_id_reg[LAT-1];

  // A CFU response with no matching tag is dropped and flagged until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      protocol_err_reg <= 1'b0;
    end else if (bus.cfu_resp_valid && !tag_valid) begin
      protocol_err_reg <= 1'b1;
    end
  end

  // Response steering back to the issuer recorded in the last tag stage.
  always_comb begin
    bus.resp_valid = '0;
    if (!rst && bus.cfu_resp_valid && tag_valid) bus.resp_valid[tag_id] = 1'b1;
    bus.resp_err = bus.resp_valid & {N_REQ{bus.cfu_resp_err}};
  end

  assign bus.resp_data       = rst ? '0 : bus.cfu_resp_data;
  assign bus.resp_err_id     = rst ? '0 : bus.cfu_resp_err_id;

  assign bus.req_ready       = ready_vec;
  assign bus.cfu_req_valid   = accept;
  assign bus.cfu_req_func_id = accept ? func_arr[grant_idx]  : '0;
  assign bus.cfu_req_data0   = accept ? data0_arr[grant_idx] : '0;
  assign bus.cfu_req_data1   = accept ? data1_arr[grant_idx] : '0;

  assign timeout      = timeout_reg & ~rst;
  assign protocol_err = protocol_err_reg & ~rst;

endmodule

// File: tb/tb_cfu_li1_share_arb.sv
// Directed bench for cfu_li1_share_arb with two requesters, latency 3 and a
// lock timeout of 8, driving a behavioural multiply-accumulate CFU
// (func 0: acc = a*b, otherwise acc += a*b; response = new acc).
module tb_cfu_li1_share_arb;
  localparam int N   = 2;
  localparam int FW  = 5;
  localparam int DW  = 32;
  localparam int RW  = 32;
  localparam int EW  = 32;
  localparam int LAT = 3;
  localparam int LT  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timeout;
  logic protocol_err;
  logic inject = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cfu_li1_share_arb_if #(.N_REQ(N), .CFU_FUNC_ID_W(FW), .CFU_REQ_DATA_W(DW),
                         .CFU_RESP_DATA_W(RW), .CFU_ERR_ID_W(EW)) bus ();

  cfu_li1_share_arb #(.N_REQ(N), .CFU_FUNC_ID_W(FW), .CFU_REQ_DATA_W(DW),
                      .CFU_RESP_DATA_W(RW), .CFU_ERR_ID_W(EW),
                      .CFU_RESP_LATENCY(LAT), .LOCK_TIMEOUT(LT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .timeout      (timeout),
    .protocol_err (protocol_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural MulAcc CFU, fixed latency LAT ----------------
  logic          mdl_vld [LAT];
  logic [RW-1:0] mdl_dat [LAT];
  logic [RW-1:0] mdl_acc;

  function automatic logic [RW-1:0] mac(input logic [FW-1:0] f, input logic [RW-1:0] acc,
                                        input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (f == '0) ? RW'(a * b) : RW'(acc + a * b);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        mdl_vld[i] <= 1'b0;
        mdl_dat[i] <= '0;
      end
      mdl_acc <= '0;
    end else begin
      mdl_vld[0] <= bus.cfu_req_valid;
      mdl_dat[0] <= mac(bus.cfu_req_func_id, mdl_acc, bus.cfu_req_data0, bus.cfu_req_data1);
      if (bus.cfu_req_valid)
        mdl_acc <= mac(bus.cfu_req_func_id, mdl_acc, bus.cfu_req_data0, bus.cfu_req_data1);
      for (int i = 1; i < LAT; i++) begin
        mdl_vld[i] <= mdl_vld[i-1];
        mdl_dat[i] <= mdl_dat[i-1];
      end
    end
  end

  assign bus.cfu_resp_valid  = mdl_vld[LAT-1] | inject;
  assign bus.cfu_resp_data   = mdl_dat[LAT-1];
  assign bus.cfu_resp_err    = inject;
  assign bus.cfu_resp_err_id = inject ? 32'h0000_0E11 : '0;

  // ------------- monitor: every accept must come back LAT cycles later -------------
  logic [N-1:0]  hist [LAT];
  int            r0_cnt = 0;
  int            r1_cnt = 0;
  logic [RW-1:0] r0_data = '0;
  logic [RW-1:0] r1_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) hist[i] <= '0;
      check_val("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    end else begin
      if (hist[LAT-1] != '0 || bus.resp_valid != '0)
        check_val("resp_route", 64'(bus.resp_valid), 64'(hist[LAT-1]));
      hist[0] <= bus.req_valid & bus.req_ready;
      for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
      if (bus.resp_valid[0]) begin
        r0_cnt  <= r0_cnt + 1;
        r0_data <= bus.resp_data;
      end
      if (bus.resp_valid[1]) begin
        r1_cnt  <= r1_cnt + 1;
        r1_data <= bus.resp_data;
      end
      if (|(bus.req_valid & bus.req_ready))
        $display("t=%0t accept ready=%b func=%0d d0=%0d d1=%0d", $time, bus.req_ready,
                 bus.cfu_req_func_id, bus.cfu_req_data0, bus.cfu_req_data1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic v, input logic last, input logic [FW-1:0] f,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_valid[i]          = v;
    bus.req_last[i]           = last;
    bus.req_func_id[i*FW +: FW] = f;
    bus.req_data0[i*DW +: DW] = a;
    bus.req_data1[i*DW +: DW] = b;
  endtask

  task automatic clear_req();
    bus.req_valid   = '0;
    bus.req_last    = '0;
    bus.req_func_id = '0;
    bus.req_data0   = '0;
    bus.req_data1   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample mid-cycle, check req_ready, then move to the next cycle.
  task automatic step_ready(input string tag, input logic [N-1:0] exp);
    @(negedge clk);
    check_val(tag, 64'(bus.req_ready), 64'(exp));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: requests present, yet every output must stay 0.
    clear_req();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd1);
    set_req(1, 1'b1, 1'b0, 5'd1, 32'd1, 32'd1);
    @(negedge clk);
    check_val("rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("rst_cfu_valid", 64'(bus.cfu_req_valid), 64'd0);
    check_val("rst_cfu_data0", 64'(bus.cfu_req_data0), 64'd0);
    check_val("rst_timeout", 64'(timeout), 64'd0);
    check_val("rst_perr", 64'(protocol_err), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    clear_req();

    // 1. Gauss sum on r0: func 0 then 100 accumulations of 1*k.
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    check_val("s1_ready_first", 64'(bus.req_ready), 64'd1);
    check_val("s1_cfu_valid", 64'(bus.cfu_req_valid), 64'd1);
    tick();
    for (int k = 1; k <= 100; k++) begin
      set_req(0, 1'b1, (k == 100), 5'd1, 32'd1, 32'(k));
      if (k == 1 || k == 100) begin
        @(negedge clk);
        check_val("s1_issue_data1", 64'(bus.cfu_req_data1), 64'(k));
        check_val("s1_issue_func", 64'(bus.cfu_req_func_id), 64'd1);
      end
      tick();
    end
    clear_req();
    repeat (3) tick();
    check_val("s1_r0_count", 64'(r0_cnt), 64'd101);
    check_val("s1_sum", 64'(r0_data), 64'd5050);
    check_val("s1_r1_count", 64'(r1_cnt), 64'd0);

    // 5. Single-op sessions, both always valid: grants alternate from rr_ptr=1.
    for (int j = 0; j < 4; j++) begin
      set_req(0, 1'b1, 1'b1, 5'd0, 32'd3, 32'(j));
      set_req(1, 1'b1, 1'b1, 5'd0, 32'd5, 32'(j));
      step_ready("s5_grant", (j % 2 == 0) ? 2'b10 : 2'b01);
    end
    clear_req();
    repeat (3) tick();
    check_val("s5_r0_data", 64'(r0_data), 64'd9);
    check_val("s5_r1_data", 64'(r1_data), 64'd10);
    check_val("s5_perr", 64'(protocol_err), 64'd0);

    // 2. Simultaneous start after reset: r0 first, r1 held off until r0's last.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd1, 32'd1);
    set_req(1, 1'b1, 1'b0, 5'd0, 32'd2, 32'd2);
    step_ready("s2_r0_first", 2'b01);
    set_req(0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd1);
    step_ready("s2_r0_locked", 2'b01);
    step_ready("s2_r0_locked", 2'b01);
    set_req(0, 1'b1, 1'b1, 5'd1, 32'd1, 32'd1);
    step_ready("s2_r0_last", 2'b01);
    set_req(0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd1);
    set_req(1, 1'b1, 1'b1, 5'd0, 32'd2, 32'd2);
    step_ready("s2_r1_next", 2'b10);
    clear_req();

    // 3. Lock holding through bubbles: r1 never ready, r0 resumes its acc.
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd4, 32'd5);
    set_req(1, 1'b1, 1'b0, 5'd1, 32'd7, 32'd7);
    step_ready("s3_lock_r0", 2'b01);
    set_req(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("s3_bubble_cfu_valid", 64'(bus.cfu_req_valid), 64'd0);
      check_val("s3_bubble_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    set_req(0, 1'b1, 1'b1, 5'd1, 32'd2, 32'd3);
    step_ready("s3_resume", 2'b01);
    clear_req();
    repeat (3) tick();
    check_val("s3_acc", 64'(r0_data), 64'd26);

    // 4a. Timeout: release after 8 idle cycles, one-cycle pulse, r1 granted.
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    step_ready("s4_lock_r0", 2'b01);
    set_req(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 1'b0, 5'd0, 32'd1, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_val("s4_idle_timeout", 64'(timeout), 64'd0);
      check_val("s4_idle_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    @(negedge clk);
    check_val("s4_pulse", 64'(timeout), 64'd1);
    check_val("s4_r1_granted", 64'(bus.req_ready), 64'd2);
    tick();
    set_req(1, 1'b1, 1'b1, 5'd1, 32'd1, 32'd1);
    @(negedge clk);
    check_val("s4_pulse_end", 64'(timeout), 64'd0);
    check_val("s4_r1_last", 64'(bus.req_ready), 64'd2);
    tick();

    // 4b. An owner op on the 8th idle cycle keeps the lock.
    set_req(1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    step_ready("s4b_lock_r0", 2'b01);
    set_req(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 1'b0, 5'd0, 32'd1, 32'd1);
    for (int i = 1; i <= 7; i++) step_ready("s4b_idle", 2'b00);
    set_req(0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd1);
    step_ready("s4b_save", 2'b01);
    set_req(0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    check_val("s4b_no_timeout", 64'(timeout), 64'd0);
    check_val("s4b_still_locked", 64'(bus.req_ready), 64'd0);
    tick();
    set_req(0, 1'b1, 1'b1, 5'd1, 32'd1, 32'd1);
    step_ready("s4b_r0_last", 2'b01);
    clear_req();

    // 6. Reset with three ops in flight: nothing delivered afterwards.
    set_req(0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    step_ready("s6_lock", 2'b01);
    set_req(0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd2);
    step_ready("s6_op2", 2'b01);
    set_req(0, 1'b1, 1'b0, 5'd1, 32'd1, 32'd3);
    step_ready("s6_op3", 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check_val("s6_rst_ready", 64'(bus.req_ready), 64'd0);
    check_val("s6_rst_cfu_valid", 64'(bus.cfu_req_valid), 64'd0);
    tick();
    rst = 1'b0;
    clear_req();
    @(negedge clk);
    check_val("s6_post_ready", 64'(bus.req_ready), 64'd0);
    check_val("s6_post_resp", 64'(bus.resp_valid), 64'd0);
    check_val("s6_post_cfu_valid", 64'(bus.cfu_req_valid), 64'd0);
    check_val("s6_post_timeout", 64'(timeout), 64'd0);
    tick();
    set_req(1, 1'b1, 1'b1, 5'd0, 32'd9, 32'd9);
    step_ready("s6_r1_first", 2'b10);
    clear_req();
    repeat (3) tick();
    check_val("s6_r1_data", 64'(r1_data), 64'd81);

    // Untagged CFU response: dropped, flagged, and sticky.
    inject = 1'b1;
    @(negedge clk);
    check_val("perr_resp_err", 64'(bus.resp_err), 64'd0);
    check_val("perr_not_yet", 64'(protocol_err), 64'd0);
    tick();
    inject = 1'b0;
    @(negedge clk);
    check_val("perr_set", 64'(protocol_err), 64'd1);
    tick();
    @(negedge clk);
    check_val("perr_sticky", 64'(protocol_err), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
